// File: rtl/axi4_lite_mem_banks_if.sv
// axi4_lite_mem_banks_if: AXI4-Lite bus bundle between a master and the banked memory slave.
interface axi4_lite_mem_banks_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 12
);
    logic [ADDR_WIDTH-1:0]   AWADDR;
    logic                    AWVALID;
    logic                    AWREADY;
    logic [DATA_WIDTH-1:0]   WDATA;
    logic [DATA_WIDTH/8-1:0] WSTRB;
    logic                    WVALID;
    logic                    WREADY;
    logic [1:0]              BRESP;
    logic                    BVALID;
    logic                    BREADY;
    logic [ADDR_WIDTH-1:0]   ARADDR;
    logic                    ARVALID;
    logic                    ARREADY;
    logic [DATA_WIDTH-1:0]   RDATA;
    logic [1:0]              RRESP;
    logic                    RVALID;
    logic                    RREADY;

    modport slave (
        input  AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
        output AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
    );

    modport master (
        output AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
        input  AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
    );
endinterface

// File: rtl/axi4_lite_mem_banks.sv
// axi4_lite_mem_banks: AXI4-Lite slave over NUM_BANKS word banks; AXI_MEM_ERRCNT_EN adds a DECERR counter.
module axi4_lite_mem_banks #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 12,
    parameter int NUM_BANKS  = 4,
    parameter int BANK_DEPTH = 128
) (
    input  logic ACLK,
    input  logic ARESETN,
`ifdef AXI_MEM_ERRCNT_EN
    input  logic        ERR_CLR,
    output logic [15:0] ERR_COUNT,
`endif
    axi4_lite_mem_banks_if.slave bus
);
    localparam int STRB_W    = DATA_WIDTH / 8;
    localparam int BYTE_OFF  = $clog2(STRB_W);
    localparam int MEM_WORDS = NUM_BANKS * BANK_DEPTH;
    localparam int IDX_W     = $clog2(MEM_WORDS);
    localparam logic [1:0] OKAY = 2'b00, DECERR = 2'b11;

    typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} w_state_e;
    typedef enum logic [1:0] {R_IDLE, R_READ, R_RESP} r_state_e;

    // Banks are contiguous, so bank*BANK_DEPTH+offset is just the word index.
    function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
        return (ADDR_WIDTH+1)'(a >> BYTE_OFF) < (ADDR_WIDTH+1)'(MEM_WORDS);
    endfunction

    function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_WIDTH-1:0] a);
        return IDX_W'(a >> BYTE_OFF);
    endfunction

    logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

    w_state_e              w_state_q, w_state_d;
    logic                  awready_q, awready_d, wready_q, wready_d;
    logic                  aw_got_q, aw_got_d, w_got_q, w_got_d;
    logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [STRB_W-1:0]     wstrb_q, wstrb_d;
    logic                  bvalid_q, bvalid_d;
    logic [1:0]            bresp_q, bresp_d;
    logic                  aw_hs, w_hs, w_commit, w_ok;

    r_state_e              r_state_q, r_state_d;
    logic                  arready_q, arready_d;
    logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
    logic                  rvalid_q, rvalid_d;
    logic [1:0]            rresp_q, rresp_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  ar_hs, r_ok;

    assign aw_hs    = bus.AWVALID & awready_q;
    assign w_hs     = bus.WVALID & wready_q;
    assign w_ok     = in_range(awaddr_q);
    assign w_commit = (w_state_q == W_WAIT) && aw_got_q && w_got_q;
    assign ar_hs    = bus.ARVALID & arready_q;
    assign r_ok     = in_range(araddr_q);

    always_comb begin
        w_state_d = w_state_q;
        awready_d = awready_q & ~aw_hs;
        wready_d  = wready_q & ~w_hs;
        aw_got_d  = aw_got_q | aw_hs;
        w_got_d   = w_got_q | w_hs;
        awaddr_d  = aw_hs ? bus.AWADDR : awaddr_q;
        wdata_d   = w_hs ? bus.WDATA : wdata_q;
        wstrb_d   = w_hs ? bus.WSTRB : wstrb_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        case (w_state_q)
            W_IDLE: begin
                awready_d = ~aw_hs;
                wready_d  = ~w_hs;
                w_state_d = (aw_hs || w_hs) ? W_WAIT : W_IDLE;
            end
            W_WAIT: if (w_commit) begin
                aw_got_d  = 1'b0;
                w_got_d   = 1'b0;
                bvalid_d  = 1'b1;
                bresp_d   = w_ok ? OKAY : DECERR;
                w_state_d = W_RESP;
            end
            W_RESP: if (bus.BREADY) begin
                bvalid_d  = 1'b0;
                awready_d = 1'b1;
                wready_d  = 1'b1;
                w_state_d = W_IDLE;
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    always_comb begin
        r_state_d = r_state_q;
        arready_d = arready_q;
        araddr_d  = ar_hs ? bus.ARADDR : araddr_q;
        rvalid_d  = rvalid_q;
        rresp_d   = rresp_q;
        rdata_d   = rdata_q;
        case (r_state_q)
            R_IDLE: begin
                arready_d = ~ar_hs;
                r_state_d = ar_hs ? R_READ : R_IDLE;
            end
            R_READ: begin
                rvalid_d  = 1'b1;
                rresp_d   = r_ok ? OKAY : DECERR;
                rdata_d   = r_ok ? mem[word_idx(araddr_q)] : '0;
                r_state_d = R_RESP;
            end
            R_RESP: if (bus.RREADY) begin
                rvalid_d  = 1'b0;
                arready_d = 1'b1;
                r_state_d = R_IDLE;
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            w_state_q <= W_IDLE;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            aw_got_q  <= 1'b0;
            w_got_q   <= 1'b0;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            bvalid_q  <= 1'b0;
            bresp_q   <= OKAY;
        end else begin
            w_state_q <= w_state_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            aw_got_q  <= aw_got_d;
            w_got_q   <= w_got_d;
            awaddr_q  <= awaddr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_state_q <= R_IDLE;
            arready_q <= 1'b0;
            araddr_q  <= '0;
            rvalid_q  <= 1'b0;
            rresp_q   <= OKAY;
            rdata_q   <= '0;
        end else begin
            r_state_q <= r_state_d;
            arready_q <= arready_d;
            araddr_q  <= araddr_d;
            rvalid_q  <= rvalid_d;
            rresp_q   <= rresp_d;
            rdata_q   <= rdata_d;
        end
    end

    // Storage has no reset; a read sampling the same edge as a commit sees the old word.
    always_ff @(posedge ACLK) begin
        if (w_commit && w_ok)
            for (int b = 0; b < STRB_W; b++)
                if (wstrb_q[b]) mem[word_idx(awaddr_q)][8*b +: 8] <= wdata_q[8*b +: 8];
    end

`ifdef AXI_MEM_ERRCNT_EN
    logic [15:0] err_q, err_d;
    logic [16:0] err_sum;
    logic        r_sample;
    assign r_sample = (r_state_q == R_READ);
    always_comb begin
        err_sum = {1'b0, err_q} + 17'(w_commit & ~w_ok) + 17'(r_sample & ~r_ok);
        err_d   = ERR_CLR ? 16'h0 : (err_sum[16] ? 16'hFFFF : err_sum[15:0]);
    end
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) err_q <= '0;
        else          err_q <= err_d;
    end
    assign ERR_COUNT = err_q;
`endif

    assign bus.AWREADY = awready_q;
    assign bus.WREADY  = wready_q;
    assign bus.BVALID  = bvalid_q;
    assign bus.BRESP   = bresp_q;
    assign bus.ARREADY = arready_q;
    assign bus.RVALID  = rvalid_q;
    assign bus.RRESP   = rresp_q;
    assign bus.RDATA   = rdata_q;
endmodule

// File: tb/tb_axi4_lite_mem_banks.sv
// tb_axi4_lite_mem_banks: directed self-checking bench for the banked AXI4-Lite memory slave.
module tb_axi4_lite_mem_banks;
    logic aclk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;
`ifdef AXI_MEM_ERRCNT_EN
    logic        err_clr = 1'b0;
    logic [15:0] err_count;
`endif

    always #5 aclk = ~aclk;

    axi4_lite_mem_banks_if #(.DATA_WIDTH(32), .ADDR_WIDTH(12)) bus ();

    axi4_lite_mem_banks #(
        .DATA_WIDTH(32), .ADDR_WIDTH(12), .NUM_BANKS(4), .BANK_DEPTH(128)
    ) dut (
        .ACLK(aclk),
        .ARESETN(rst_n),
`ifdef AXI_MEM_ERRCNT_EN
        .ERR_CLR(err_clr),
        .ERR_COUNT(err_count),
`endif
        .bus(bus)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic axi_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s,
                             input logic [1:0] resp);
        chk("w_awready_idle", bus.AWREADY, 1);
        chk("w_wready_idle", bus.WREADY, 1);
        bus.AWADDR = a; bus.AWVALID = 1'b1;
        bus.WDATA = d; bus.WSTRB = s; bus.WVALID = 1'b1;
        step();
        bus.AWVALID = 1'b0; bus.WVALID = 1'b0;
        chk("w_awready_drop", bus.AWREADY, 0);
        chk("w_bvalid_early", bus.BVALID, 0);
        step();
        chk("w_bvalid", bus.BVALID, 1);
        chk("w_bresp", bus.BRESP, resp);
        bus.BREADY = 1'b1;
        step();
        bus.BREADY = 1'b0;
        chk("w_bvalid_clr", bus.BVALID, 0);
    endtask

    task automatic axi_read(input logic [11:0] a, input logic [31:0] d, input logic [1:0] resp);
        chk("r_arready_idle", bus.ARREADY, 1);
        bus.ARADDR = a; bus.ARVALID = 1'b1;
        step();
        bus.ARVALID = 1'b0;
        chk("r_arready_drop", bus.ARREADY, 0);
        chk("r_rvalid_early", bus.RVALID, 0);
        step();
        chk("r_rvalid", bus.RVALID, 1);
        chk("r_rdata", bus.RDATA, d);
        chk("r_rresp", bus.RRESP, resp);
        bus.RREADY = 1'b1;
        step();
        bus.RREADY = 1'b0;
        chk("r_rvalid_clr", bus.RVALID, 0);
        chk("r_arready_back", bus.ARREADY, 1);
    endtask

    task automatic axi_both(input logic [11:0] a, input logic [31:0] d, input logic [31:0] old_d,
                            input logic [1:0] resp);
        bus.AWADDR = a; bus.AWVALID = 1'b1;
        bus.WDATA = d; bus.WSTRB = 4'hF; bus.WVALID = 1'b1;
        bus.ARADDR = a; bus.ARVALID = 1'b1;
        step();
        bus.AWVALID = 1'b0; bus.WVALID = 1'b0; bus.ARVALID = 1'b0;
        step();
        chk("c_bvalid", bus.BVALID, 1);
        chk("c_rvalid", bus.RVALID, 1);
        chk("c_rdata_old", bus.RDATA, old_d);
        chk("c_rresp", bus.RRESP, resp);
        bus.BREADY = 1'b1; bus.RREADY = 1'b1;
        step();
        bus.BREADY = 1'b0; bus.RREADY = 1'b0;
        chk("c_valids_clr", {bus.BVALID, bus.RVALID}, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.AWADDR = '0; bus.AWVALID = 1'b0; bus.WDATA = '0; bus.WSTRB = '0; bus.WVALID = 1'b0;
        bus.BREADY = 1'b0; bus.ARADDR = '0; bus.ARVALID = 1'b0; bus.RREADY = 1'b0;
        repeat (3) step();
        chk("rst_readys", {bus.AWREADY, bus.WREADY, bus.ARREADY}, 0);
        chk("rst_valids", {bus.BVALID, bus.RVALID}, 0);
        chk("rst_resp_data", {bus.BRESP, bus.RRESP, bus.RDATA}, 0);
        rst_n = 1'b1;
        #1;
        chk("rel_readys_low", {bus.AWREADY, bus.WREADY, bus.ARREADY}, 0);
        step();
        chk("rel_readys_high", {bus.AWREADY, bus.WREADY, bus.ARREADY}, 3'b111);
`ifdef AXI_MEM_ERRCNT_EN
        chk("err_rst", err_count, 0);
`endif

        axi_write(12'h204, 32'hDEADBEEF, 4'hF, 2'b00);
        axi_read(12'h204, 32'hDEADBEEF, 2'b00);
        axi_read(12'h207, 32'hDEADBEEF, 2'b00);

        axi_write(12'h000, 32'h11223344, 4'hF, 2'b00);
        axi_write(12'h000, 32'hAABBCCDD, 4'h5, 2'b00);
        axi_read(12'h000, 32'h11BB33DD, 2'b00);
        axi_write(12'h002, 32'hFFFFFFFF, 4'h0, 2'b00);
        axi_read(12'h000, 32'h11BB33DD, 2'b00);

        // AW leads W by three cycles; BVALID then held under BREADY=0
        bus.AWADDR = 12'h100; bus.AWVALID = 1'b1;
        step();
        bus.AWVALID = 1'b0;
        chk("aw_first_awready", bus.AWREADY, 0);
        chk("aw_first_wready", bus.WREADY, 1);
        step();
        step();
        chk("aw_wait_awready", bus.AWREADY, 0);
        chk("aw_wait_bvalid", bus.BVALID, 0);
        bus.WDATA = 32'hCAFEF00D; bus.WSTRB = 4'hF; bus.WVALID = 1'b1;
        step();
        bus.WVALID = 1'b0;
        chk("w_late_wready", bus.WREADY, 0);
        chk("w_late_bvalid0", bus.BVALID, 0);
        step();
        for (int i = 0; i < 5; i++) begin
            chk("hold_bvalid", bus.BVALID, 1);
            chk("hold_bresp", bus.BRESP, 2'b00);
            step();
        end
        bus.BREADY = 1'b1;
        step();
        bus.BREADY = 1'b0;
        chk("hold_release", {bus.BVALID, bus.AWREADY, bus.WREADY}, 3'b011);
        axi_read(12'h100, 32'hCAFEF00D, 2'b00);

        axi_write(12'h800, 32'h12345678, 4'hF, 2'b11);
        axi_read(12'h800, 32'h0, 2'b11);
        axi_read(12'h000, 32'h11BB33DD, 2'b00);
`ifdef AXI_MEM_ERRCNT_EN
        chk("err_two", err_count, 2);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        chk("err_clr", err_count, 0);
        axi_both(12'hFFC, 32'h1, 32'h0, 2'b11);
        chk("err_same_edge", err_count, 2);
`endif

        axi_write(12'h000, 32'h5, 4'hF, 2'b00);
        axi_write(12'h600, 32'h7, 4'hF, 2'b00);
        axi_read(12'h000, 32'h5, 2'b00);
        axi_read(12'h600, 32'h7, 2'b00);

        axi_write(12'h010, 32'hA5A5A5A5, 4'hF, 2'b00);
        axi_both(12'h010, 32'h5A5A5A5A, 32'hA5A5A5A5, 2'b00);
        axi_read(12'h010, 32'h5A5A5A5A, 2'b00);

        // reset while BVALID is pending
        bus.AWADDR = 12'h020; bus.AWVALID = 1'b1;
        bus.WDATA = 32'h12345678; bus.WSTRB = 4'hF; bus.WVALID = 1'b1;
        step();
        bus.AWVALID = 1'b0; bus.WVALID = 1'b0;
        step();
        chk("pre_rst_bvalid", bus.BVALID, 1);
        rst_n = 1'b0;
        #1;
        chk("async_rst", {bus.AWREADY, bus.WREADY, bus.ARREADY, bus.BVALID, bus.RVALID}, 0);
        step();
        rst_n = 1'b1;
        step();
        chk("post_rst_readys", {bus.AWREADY, bus.WREADY, bus.ARREADY}, 3'b111);
        repeat (3) begin
            chk("no_stale_bvalid", bus.BVALID, 0);
            step();
        end

        // both halves captured, reset before the commit edge
        axi_write(12'h030, 32'h0BADF00D, 4'hF, 2'b00);
        bus.AWADDR = 12'h030; bus.AWVALID = 1'b1;
        bus.WDATA = 32'hFFFFFFFF; bus.WSTRB = 4'hF; bus.WVALID = 1'b1;
        step();
        bus.AWVALID = 1'b0; bus.WVALID = 1'b0;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        axi_read(12'h030, 32'h0BADF00D, 2'b00);
        chk("partial_no_bvalid", bus.BVALID, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/axi4_lite_mem_banks.md
Name: axi4_lite_mem_banks

Overview:
- Parametrised AXI4-Lite slave fronting NUM_BANKS independent word-addressed memory banks.
- Next generation of the team's two-bank AXI4-Lite memory slave: configurable data width, address width, bank count and depth.
- Adds decode-error responses and fully independent read and write state machines.
- Sits behind the interconnect as a register-file/scratch memory target.

Parameters:
- DATA_WIDTH, 32, bus/word width; 32 or 64 only.
- ADDR_WIDTH, 12, byte address width of AWADDR/ARADDR.
- NUM_BANKS, 4, number of banks; 1..16.
- BANK_DEPTH, 128, words per bank; power of two.

Ports:
- ACLK  in  1  clock
- ARESETN  in  1  reset
- AWADDR  in  ADDR_WIDTH  write byte address
- AWVALID  in  1  write address valid
- AWREADY  out  1  write address ready
- WDATA  in  DATA_WIDTH  write data
- WSTRB  in  DATA_WIDTH/8  byte strobes
- WVALID  in  1  write data valid
- WREADY  out  1  write data ready
- BRESP  out  2  write response
- BVALID  out  1  write response valid
- BREADY  in  1  write response ready
- ARADDR  in  ADDR_WIDTH  read byte address
- ARVALID  in  1  read address valid
- ARREADY  out  1  read address ready
- RDATA  out  DATA_WIDTH  read data
- RRESP  out  2  read response
- RVALID  out  1  read data valid
- RREADY  in  1  read data ready

Behaviour:
- Clock and reset: single clock ACLK, rising edge. ARESETN is asynchronous, active-low.
- Reset values: AWREADY, WREADY, ARREADY, BVALID and RVALID are 0; BRESP, RRESP and RDATA are 0. All state machines return to IDLE.
- Memory contents are not reset.
- Readys rise on the first clock edge after reset release.
- Address decode:
  - Word index = addr >> log2(DATA_WIDTH/8); low byte-offset bits are ignored.
  - Bank = word index / BANK_DEPTH; offset = word index % BANK_DEPTH.
  - Bank >= NUM_BANKS is a decode error: response DECERR (2'b11), no memory access. Valid accesses respond OKAY (2'b00).
- Write FSM, states W_IDLE, W_WAIT, W_RESP:
  - W_IDLE: AWREADY=1 and WREADY=1.
  - AW and W are accepted independently; each ready drops to 0 the cycle after its own handshake. Addr, data and strobe are held.
  - W_WAIT: one of AW/W has been captured; the FSM waits for the other.
  - On the edge following capture of both (same-edge capture allowed): bytes with WSTRB set are written, BVALID=1, BRESP set, state W_RESP.
  - Latency: both handshakes at edge N gives the write and BVALID at edge N+1.
  - W_RESP: BVALID and BRESP are held stable until BREADY=1. On that edge BVALID=0, state W_IDLE, readys=1.
  - WSTRB=0 is a legal no-op write with OKAY response.
- Read FSM, states R_IDLE, R_READ, R_RESP:
  - R_IDLE: ARREADY=1. On handshake at edge N: capture the address, ARREADY=0, state R_READ.
  - Edge N+1: RDATA = bank word (0 on DECERR), RRESP set, RVALID=1, state R_RESP.
  - R_RESP: RDATA, RRESP and RVALID are held until RREADY=1. On that edge RVALID=0, ARREADY=1, state R_IDLE.
- Concurrency:
  - Read and write FSMs are fully independent.
  - If a read sample and a write commit hit the same word on the same edge, the read returns the old data.
- Reset mid-transaction: any pending transaction is discarded with no response. A partially captured write is not committed.
- Unaligned addresses are not an error; they are silently aligned down.

Optional Feature:
- AXI_MEM_ERRCNT_EN defined:
  - Adds ports ERR_COUNT (out, 16) and ERR_CLR (in, 1).
  - ERR_COUNT increments by 1 on each edge where a DECERR response is issued (BVALID or RVALID rising with DECERR). It increments by 2 if both rise on the same edge.
  - ERR_COUNT saturates at 16'hFFFF and resets to 0.
  - ERR_CLR=1 zeroes the count; clear wins over increment.
- Not defined: these ports and the counter do not exist; all other behaviour is identical.

Test Plan:
- Defaults; write 0xDEADBEEF to 0x204 with WSTRB=0xF, then read 0x204: BRESP=00, RDATA=0xDEADBEEF, RRESP=00. RVALID is asserted 1 cycle after the AR handshake.
- Write 0x11223344 to 0x000 (strobe 0xF), then 0xAABBCCDD with WSTRB=0x5, then read 0x000: RDATA=0x11BB33DD.
- AW presented 3 cycles before W: AWREADY low after capture, BVALID 1 cycle after W handshake. Holding BREADY=0 for 5 cycles keeps BVALID=1 and BRESP stable.
- Write and read to 0x800 (bank 4 of 4): BRESP=11, RRESP=11, RDATA=0. A following read of 0x000 still returns the prior data. With AXI_MEM_ERRCNT_EN, ERR_COUNT=2.
- Write 0x5 to bank 0 offset 0 and 0x7 to bank 3 offset 0 (byte 0x600); read both back: 0x5 and 0x7, confirming no bank aliasing.
- Deassert ARESETN while BVALID=1 with BREADY=0: all valids/readys go to 0 immediately. After release, readys return to 1 and no stale BVALID appears.
